// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - 8N1 (optional parity) serial receiver with byte FIFO and error pulses
module uart_rx_monitor #(
    parameter int unsigned ClksPerBit = 16,
    parameter int unsigned ParityEn   = 0,
    parameter int unsigned ParityOdd  = 0,
    parameter int unsigned FifoDepth  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        rx_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        frame_err_o,
    output logic        parity_err_o,
    output logic        overflow_o,
    output logic [15:0] overflow_cnt_o,
    output logic        busy_o
);

    localparam int unsigned AW = $clog2(FifoDepth);
    localparam logic [15:0] HalfLoad   = 16'(ClksPerBit / 2 - 1);
    localparam logic [15:0] BitLoad    = 16'(ClksPerBit - 1);
    localparam logic        ParityOddB = (ParityOdd != 0);
    localparam logic [AW:0]   DepthV   = (AW + 1)'(FifoDepth);
    localparam logic [AW:0]   CntOne   = (AW + 1)'(1);
    localparam logic [AW-1:0] PtrOne   = AW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_e;

    logic        sync1_q;
    logic        rx_s_q;
    logic        rx_prev_q;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        par_err_q;
    logic        frame_err_q;
    logic        parity_err_q;
    logic        overflow_q;
    logic [15:0] overflow_cnt_q;

    logic [7:0]    mem_q [FifoDepth];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    logic tick;
    logic stop_ok;
    logic pop;
    logic full;
    logic push;
    logic drop;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx_i;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_comb begin
        tick    = (cnt_q == 16'd0);
        stop_ok = enable_i && (state_q == ST_STOP) && tick && rx_s_q && !par_err_q;
        pop     = rx_valid_o && rx_ready_i;
        full    = (count_q == DepthV);
        push    = stop_ok && (!full || pop);
        drop    = stop_ok && full && !pop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            if (!enable_i) begin
                state_q   <= ST_IDLE;
                par_err_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_prev_q && !rx_s_q) begin
                            state_q   <= ST_START;
                            cnt_q     <= HalfLoad;
                            par_err_q <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (tick) begin
                            cnt_q     <= BitLoad;
                            bit_idx_q <= 3'd0;
                            state_q   <= rx_s_q ? ST_IDLE : ST_DATA;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (tick) begin
                            cnt_q     <= BitLoad;
                            shift_q   <= {rx_s_q, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                state_q <= (ParityEn != 0) ? ST_PARITY : ST_STOP;
                            end
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (tick) begin
                            cnt_q     <= BitLoad;
                            par_err_q <= (rx_s_q != ((^shift_q) ^ ParityOddB));
                            state_q   <= ST_STOP;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_STOP: begin
                        if (tick) begin
                            cnt_q <= BitLoad;
                            if (!rx_s_q) begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_WAIT_IDLE;
                            end else begin
                                parity_err_q <= par_err_q;
                                state_q      <= ST_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (rx_s_q) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q     <= 1'b0;
            overflow_cnt_q <= 16'd0;
        end else begin
            overflow_q <= drop;
            if (drop && (overflow_cnt_q != 16'hFFFF)) begin
                overflow_cnt_q <= overflow_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                mem_q[i] <= 8'd0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
            end
            count_q <= count_d;
        end
    end

    assign rx_data_o      = mem_q[rptr_q];
    assign rx_valid_o     = (count_q != '0);
    assign frame_err_o    = frame_err_q;
    assign parity_err_o   = parity_err_q;
    assign overflow_o     = overflow_q;
    assign overflow_cnt_o = overflow_cnt_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - directed and random frame stimulus against a queue-based receive model
module tb_uart_rx_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        rx_m = 1'b1;
    logic        rx_p = 1'b1;
    logic        rdy_m = 1'b0;
    logic        rdy_p = 1'b0;

    logic [7:0]  data_m, data_p;
    logic        valid_m, valid_p;
    logic        fe_m_o, fe_p_o, pe_m_o, pe_p_o, ov_m_o, ov_p_o;
    logic [15:0] ovc_m, ovc_p;
    logic        busy_m, busy_p;

    uart_rx_monitor #(.ClksPerBit(16), .ParityEn(0), .ParityOdd(0), .FifoDepth(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .rx_i(rx_m),
        .rx_data_o(data_m), .rx_valid_o(valid_m), .rx_ready_i(rdy_m),
        .frame_err_o(fe_m_o), .parity_err_o(pe_m_o), .overflow_o(ov_m_o),
        .overflow_cnt_o(ovc_m), .busy_o(busy_m)
    );

    uart_rx_monitor #(.ClksPerBit(16), .ParityEn(1), .ParityOdd(1), .FifoDepth(4)) u_dut_p (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .rx_i(rx_p),
        .rx_data_o(data_p), .rx_valid_o(valid_p), .rx_ready_i(rdy_p),
        .frame_err_o(fe_p_o), .parity_err_o(pe_p_o), .overflow_o(ov_p_o),
        .overflow_cnt_o(ovc_p), .busy_o(busy_p)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fe_m = 0, pe_m = 0, ov_m = 0, fe_p = 0, pe_p = 0, busy_cnt = 0;
    int rise_cyc = -1;
    logic valid_m_prev = 1'b0;
    bit log_m = 1'b0, log_p = 1'b0;
    logic [7:0] got_m[$];
    logic [7:0] got_p[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fe_m_o === 1'b1) fe_m++;
        if (pe_m_o === 1'b1) pe_m++;
        if (ov_m_o === 1'b1) ov_m++;
        if (fe_p_o === 1'b1) fe_p++;
        if (pe_p_o === 1'b1) pe_p++;
        if (busy_m === 1'b1) busy_cnt++;
        if (valid_m === 1'b1 && valid_m_prev !== 1'b1) rise_cyc = cyc;
        valid_m_prev = valid_m;
        if (log_m && valid_m === 1'b1 && rdy_m === 1'b1) got_m.push_back(data_m);
        if (log_p && valid_p === 1'b1 && rdy_p === 1'b1) got_p.push_back(data_p);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line(input bit p, input logic v, input int n);
        if (p) rx_p = v;
        else   rx_m = v;
        tick(n);
    endtask

    task automatic send(input bit p, input logic [7:0] b, input logic stop_v, input logic par_v);
        line(p, 1'b0, 16);
        for (int i = 0; i < 8; i++) line(p, b[i], 16);
        if (p) line(p, par_v, 16);
        line(p, stop_v, 16);
    endtask

    task automatic pop(input bit p, input logic [7:0] exp, input string tag);
        if (p) begin
            chk({tag, "_valid"}, {31'd0, valid_p}, 32'd1);
            chk({tag, "_data"}, {24'd0, data_p}, {24'd0, exp});
            rdy_p = 1'b1; tick(1); rdy_p = 1'b0;
        end else begin
            chk({tag, "_valid"}, {31'd0, valid_m}, 32'd1);
            chk({tag, "_data"}, {24'd0, data_m}, {24'd0, exp});
            rdy_m = 1'b1; tick(1); rdy_m = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, e0, b0, f0, o0, p0, nbad, gi, ones;
        logic [7:0] b;
        logic bad, par;
        logic [7:0] q[$];

        tick(3);
        chk("reset_outs_m", {data_m, valid_m, fe_m_o, pe_m_o, ov_m_o, busy_m, ovc_m}, 32'd0);
        chk("reset_outs_p", {data_p, valid_p, fe_p_o, pe_p_o, ov_p_o, busy_p, ovc_p}, 32'd0);
        rst_n = 1'b1;
        tick(4);

        // Single byte: latency from pin fall to rx_valid_o
        t0 = cyc;
        send(0, 8'h55, 1'b1, 1'b0);
        chk("t1_rise_cycle", rise_cyc - t0, 32'd155);
        pop(0, 8'h55, "t1");
        chk("t1_no_errors", fe_m + pe_m + ov_m, 32'd0);

        // Back-to-back frames drained as they arrive
        gi = got_m.size();
        log_m = 1'b1; rdy_m = 1'b1;
        send(0, 8'h41, 1'b1, 1'b0);
        send(0, 8'h0A, 1'b1, 1'b0);
        tick(20);
        log_m = 1'b0; rdy_m = 1'b0;
        chk("t2_count", got_m.size() - gi, 32'd2);
        chk("t2_first", {24'd0, got_m[gi]}, 32'h41);
        chk("t2_second", {24'd0, got_m[gi+1]}, 32'h0A);
        chk("t2_empty", {31'd0, valid_m}, 32'd0);

        // Short low glitch: start check fails at half a bit
        e0 = fe_m + pe_m + ov_m;
        b0 = busy_cnt;
        line(0, 1'b0, 3);
        line(0, 1'b1, 30);
        chk("t3_busy_len", busy_cnt - b0, 32'd8);
        chk("t3_no_push", {31'd0, valid_m}, 32'd0);
        chk("t3_no_errors", fe_m + pe_m + ov_m - e0, 32'd0);

        // Stop bit low followed by a long break
        f0 = fe_m;
        send(0, 8'hA5, 1'b0, 1'b0);
        line(0, 1'b0, 40 * 16 - 16);
        chk("t4_busy_hold", {31'd0, busy_m}, 32'd1);
        chk("t4_frame_err", fe_m - f0, 32'd1);
        chk("t4_no_push", {31'd0, valid_m}, 32'd0);
        line(0, 1'b1, 8);
        chk("t4_idle_again", {31'd0, busy_m}, 32'd0);

        // Overflow: five bytes into a four-entry FIFO
        q.delete();
        o0 = ov_m;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            if (q.size() < 4) q.push_back(b);
            send(0, b, 1'b1, 1'b0);
        end
        chk("t5_ovf_cnt", {16'd0, ovc_m}, 32'd1);
        chk("t5_ovf_pulses", ov_m - o0, 32'd1);
        // Push while full, coinciding with a pop, must not overflow
        b = 8'($urandom);
        fork
            send(0, b, 1'b1, 1'b0);
            begin
                tick(154);
                chk("t5_head_before_swap", {24'd0, data_m}, {24'd0, q[0]});
                rdy_m = 1'b1; tick(1); rdy_m = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(b);
        chk("t5_swap_no_ovf", {16'd0, ovc_m}, 32'd1);
        while (q.size() > 0) pop(0, q.pop_front(), "t5_drain");
        chk("t5_empty", {31'd0, valid_m}, 32'd0);

        // Odd parity: wrong bit then correct bit
        p0 = pe_p;
        send(1, 8'h03, 1'b1, 1'b0);
        chk("t6_parity_err", pe_p - p0, 32'd1);
        chk("t6_no_push", {31'd0, valid_p}, 32'd0);
        send(1, 8'h03, 1'b1, 1'b1);
        pop(1, 8'h03, "t6");
        chk("t6_single_pulse", pe_p - p0, 32'd1);

        // Random parity frames, some with the wrong parity bit
        q.delete();
        p0 = pe_p; nbad = 0; gi = got_p.size();
        log_p = 1'b1; rdy_p = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 2) == 0);
            ones = $countones(b);
            par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
            if (bad) begin
                par = ~par;
                nbad++;
            end else begin
                q.push_back(b);
            end
            send(1, b, 1'b1, par);
            line(1, 1'b1, $urandom_range(0, 12));
        end
        tick(10);
        log_p = 1'b0; rdy_p = 1'b0;
        chk("t7_par_count", got_p.size() - gi, q.size());
        for (int i = 0; i < q.size(); i++) chk("t7_par_byte", {24'd0, got_p[gi+i]}, {24'd0, q[i]});
        chk("t7_par_errs", pe_p - p0, nbad);
        chk("t7_par_fe", fe_p, 32'd0);

        // Random frames on the plain receiver, some with a bad stop bit
        q.delete();
        f0 = fe_m; nbad = 0; gi = got_m.size();
        log_m = 1'b1; rdy_m = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            if (bad) nbad++;
            else     q.push_back(b);
            send(0, b, ~bad, 1'b0);
            line(0, 1'b1, $urandom_range(4, 20));
        end
        tick(10);
        log_m = 1'b0; rdy_m = 1'b0;
        chk("t8_count", got_m.size() - gi, q.size());
        for (int i = 0; i < q.size(); i++) chk("t8_byte", {24'd0, got_m[gi+i]}, {24'd0, q[i]});
        chk("t8_frame_errs", fe_m - f0, nbad);

        // Disable mid-frame: frame dropped, FIFO kept
        send(0, 8'h3C, 1'b1, 1'b0);
        e0 = fe_m + pe_m + ov_m;
        line(0, 1'b0, 40);
        en = 1'b0;
        tick(1);
        chk("t9_disable_idle", {31'd0, busy_m}, 32'd0);
        line(0, 1'b1, 200);
        en = 1'b1;
        tick(5);
        chk("t9_fifo_kept", {23'd0, valid_m, data_m}, {23'd0, 1'b1, 8'h3C});
        chk("t9_kept_ovc", {16'd0, ovc_m}, 32'd1);
        chk("t9_no_errors", fe_m + pe_m + ov_m - e0, 32'd0);

        // Reset during data bit 4, then a clean frame
        b = 8'h7E;
        line(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) line(0, b[i], 16);
        line(0, b[4], 8);
        chk("t10_busy_before", {31'd0, busy_m}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t10_reset_outs", {data_m, valid_m, fe_m_o, pe_m_o, ov_m_o, busy_m, ovc_m}, 32'd0);
        rx_m = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        send(0, 8'h7E, 1'b1, 1'b0);
        pop(0, 8'h7E, "t10");
        chk("t10_empty", {31'd0, valid_m}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Simulation-side serial receiver that sits directly downstream of the chip's UART TX pin (cio_uart_tx_d2p).
- Deserialises 8N1 frames (parity optional) into bytes and buffers them in a small FIFO with a valid/ready output.
- Reports framing errors, parity errors and overflows.
- Lets the bench check console output at the pin instead of probing internal UART core signals.

Parameters:
- ClksPerBit, 16, clk_i cycles per serial bit; legal range 4..65535.
- ParityEn, 0, 1 = a parity bit follows the data bits.
- ParityOdd, 0, parity sense when ParityEn = 1 (0 = even, 1 = odd).
- FifoDepth, 4, receive FIFO entries; power of two, 2..64.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- enable_i  input  1  receiver enable.
- rx_i  input  1  serial line; idles high.
- rx_data_o  output  8  FIFO head byte.
- rx_valid_o  output  1  FIFO non-empty.
- rx_ready_i  input  1  consumer pops the head when rx_valid_o && rx_ready_i.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- parity_err_o  output  1  one-cycle pulse: parity mismatch.
- overflow_o  output  1  one-cycle pulse: good byte dropped because the FIFO was full.
- overflow_cnt_o  output  16  saturating count of dropped bytes.
- busy_o  output  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is rst_ni, asynchronous assert, active low.
- Reset values:
  - All outputs 0; rx_data_o reads 0.
  - Synchroniser flops reset to 1; FIFO empty; FSM in IDLE.
- Input sync: rx_i passes through a 2-flop synchroniser; rx_s is the synchronised value.
- Start detection: in IDLE with enable_i = 1, a 1->0 transition of rx_s in cycle T0 goes to START and loads the bit counter with ClksPerBit/2 - 1 (floor).
- Bit counter: decrements each cycle. At 0 the current bit is sampled and the counter reloads ClksPerBit - 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - START: at sample, rx_s = 0 -> DATA. rx_s = 1 -> IDLE (glitch, nothing reported).
  - DATA: 8 samples, LSB first, shifted into a byte register, then PARITY if ParityEn else STOP.
  - PARITY: sample the bit and compare with XOR(data) ^ ParityOdd. Any mismatch is remembered.
  - STOP, sample 1, no parity error: push the byte if the FIFO is not full. If full, drop it, pulse overflow_o and increment overflow_cnt_o (saturates at 16'hFFFF). Go to IDLE.
  - STOP, sample 1, parity error: pulse parity_err_o, no push, go to IDLE.
  - STOP, sample 0: pulse frame_err_o, no push (takes precedence over a parity error), go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1, then go to IDLE. This covers line breaks.
- Timing without parity:
  - Data bit i is sampled at T0 + ClksPerBit/2 + (i+1)*ClksPerBit.
  - Stop bit is sampled at T0 + ClksPerBit/2 + 9*ClksPerBit.
  - Error pulses occur in the cycle after the stop sample. The pushed byte is visible on rx_valid_o/rx_data_o in that same cycle.
  - Add ClksPerBit cycles when ParityEn = 1.
- FIFO:
  - Head is presented combinationally from storage.
  - A simultaneous push and pop in the same cycle is allowed, including when full. A pop frees the slot that cycle, so no overflow occurs.
  - Pop when empty is ignored.
- enable_i = 0: the FSM goes to IDLE the next cycle, the in-progress frame is discarded with no error pulses, and FIFO contents and overflow_cnt_o are retained.
- Reset mid-frame: everything returns to reset values immediately. The next frame is received normally once rx_s has been high for one cycle after reset release.

Test Plan:
- ClksPerBit = 16, send 0x55 with pin falling at cycle 0, rx_ready_i = 0 -> rx_valid_o rises at cycle 155 with rx_data_o = 0x55; no error pulses.
- Send 0x41 then 0x0A back-to-back with rx_ready_i = 1 -> two pops, 0x41 then 0x0A, in order.
- 3-cycle low glitch on an idle line -> no push, no error pulse; busy_o drops about 8 cycles after the glitch is detected.
- Frame 0xA5 with stop bit forced 0 and the line held low 40 bit-times -> one frame_err_o pulse, FIFO empty, busy_o held until the line returns high.
- FifoDepth = 4, rx_ready_i = 0, send 5 bytes -> 4 bytes stored, one overflow_o pulse, overflow_cnt_o = 1. Then pop all -> bytes 1..4 in order.
- ParityEn = 1, ParityOdd = 1, send 0x03 with parity bit 0 -> parity_err_o pulse, no push. Resend with parity bit 1 -> rx_data_o = 0x03.
- Assert rst_ni low at data bit 4 of a frame -> all outputs 0 immediately; the next full frame 0x7E is received correctly.
